// File: rtl/cache_flush_sequencer.sv
// Batches cache-invalidate requests from several control units and runs a
// stall -> D-flush -> I-flush -> release handshake per batch, acking each served requester.
module cache_flush_sequencer #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [2*NREQ-1:0]   req_tgt,
    output logic [NREQ-1:0]     ack,
    output logic                busy,
    output logic                pipe_stall,
    input  logic                pipe_idle,
    output logic                dflush_req,
    input  logic                dflush_done,
    output logic                iflush_req,
    input  logic                iflush_done,
    output logic                timeout_err,
    input  logic                err_clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH_D,
        S_FLUSH_I,
        S_RELEASE
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [NREQ-1:0]        pend_q, pend_d;
    logic [NREQ-1:0][1:0]   ptgt_q, ptgt_d;
    logic [NREQ-1:0][1:0]   tgt_norm;
    logic [NREQ-1:0]        pend_clr;
    logic [NREQ-1:0]        batch_q, batch_d;
    logic [1:0]             btgt_q, btgt_d;
    logic [1:0]             btgt_gather;
    logic [7:0]             timer_q, timer_d;
    logic                   timeout_hit;

    logic [NREQ-1:0]        ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   stall_q, stall_d;
    logic                   dreq_q, dreq_d;
    logic                   ireq_q, ireq_d;
    logic                   err_q, err_d;

    // Per requester: bit 0 = D-cache, bit 1 = I-cache; an empty target means both.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pend
        always_comb begin
            tgt_norm[gi] = req_tgt[2*gi +: 2];
            if (tgt_norm[gi] == 2'b00) begin
                tgt_norm[gi] = 2'b11;
            end
            pend_d[gi] = (pend_q[gi] & ~pend_clr[gi]) | req[gi];
            ptgt_d[gi] = (pend_clr[gi] ? 2'b00 : ptgt_q[gi]) |
                         (req[gi] ? tgt_norm[gi] : 2'b00);
        end
    end

    always_comb begin
        btgt_gather = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (pend_q[i]) begin
                btgt_gather = btgt_gather | ptgt_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        batch_d     = batch_q;
        btgt_d      = btgt_q;
        pend_clr    = '0;
        timeout_hit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    batch_d  = pend_q;
                    btgt_d   = btgt_gather;
                    pend_clr = pend_q;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pipe_idle) begin
                    state_d = btgt_q[0] ? S_FLUSH_D : S_FLUSH_I;
                end
            end
            S_FLUSH_D: begin
                // The done input is ignored on the request cycle itself.
                if ((timer_q != 8'd0) && dflush_done) begin
                    state_d = btgt_q[1] ? S_FLUSH_I : S_RELEASE;
                end else if (timer_q == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_d     = btgt_q[1] ? S_FLUSH_I : S_RELEASE;
                end
            end
            S_FLUSH_I: begin
                if ((timer_q != 8'd0) && iflush_done) begin
                    state_d = S_RELEASE;
                end else if (timer_q == TIMEOUT_CNT) begin
                    timeout_hit = 1'b1;
                    state_d     = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        timer_d = 8'd0;
        if ((state_d == state_q) && ((state_q == S_FLUSH_D) || (state_q == S_FLUSH_I))) begin
            timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
        end
    end

    // Outputs are registered against the next state so they line up with the state they describe.
    always_comb begin
        ack_d   = (state_d == S_RELEASE) ? batch_d : '0;
        busy_d  = (state_d != S_IDLE) | (|pend_d);
        stall_d = (state_d == S_DRAIN) || (state_d == S_FLUSH_D) || (state_d == S_FLUSH_I);
        dreq_d  = (state_d == S_FLUSH_D) && (state_q != S_FLUSH_D);
        ireq_d  = (state_d == S_FLUSH_I) && (state_q != S_FLUSH_I);
        err_d   = timeout_hit | (err_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            ptgt_q  <= '0;
            batch_q <= '0;
            btgt_q  <= 2'b00;
            timer_q <= 8'd0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            stall_q <= 1'b0;
            dreq_q  <= 1'b0;
            ireq_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ptgt_q  <= ptgt_d;
            batch_q <= batch_d;
            btgt_q  <= btgt_d;
            timer_q <= timer_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
            dreq_q  <= dreq_d;
            ireq_q  <= ireq_d;
            err_q   <= err_d;
        end
    end

    assign ack         = ack_q;
    assign busy        = busy_q;
    assign pipe_stall  = stall_q;
    assign dflush_req  = dreq_q;
    assign iflush_req  = ireq_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_cache_flush_sequencer.sv
// Scoreboarded bench for cache_flush_sequencer: expected acks are queued at request time
// and matched as ack pulses appear; cycle-exact checks cover the handshake timing.
module tb_cache_flush_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] req_tgt = '0;
    logic [3:0] ack;
    logic       busy, pipe_stall, dflush_req, iflush_req, timeout_err;
    logic       pipe_idle = 1'b1;
    logic       dflush_done, iflush_done;
    logic       err_clr = 1'b0;
    logic       man_dd = 1'b0, man_di = 1'b0;
    logic       auto_dd = 1'b0, auto_di = 1'b0;
    bit         auto_d_en = 1'b0, auto_i_en = 1'b0;
    int         d_cnt = 0, i_cnt = 0;
    int         cyc = 0, d_cyc = -1, i_cyc = -1;
    int         checks = 0, errors = 0;
    logic [3:0] exp_q[$];

    assign dflush_done = man_dd | auto_dd;
    assign iflush_done = man_di | auto_di;

    always #5 clk = ~clk;

    cache_flush_sequencer #(.NREQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_tgt(req_tgt), .ack(ack), .busy(busy),
        .pipe_stall(pipe_stall), .pipe_idle(pipe_idle), .dflush_req(dflush_req),
        .dflush_done(dflush_done), .iflush_req(iflush_req), .iflush_done(iflush_done),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    // One clock: sample just after the edge, score acks, emulate the flush adapters.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ack != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", int'(ack), 0);
            end else begin
                check("ack", int'(ack), int'(exp_q.pop_front()));
            end
            $display("cycle %0d ack=%b", cyc, ack);
        end
        auto_dd = 1'b0;
        auto_di = 1'b0;
        if (d_cnt > 0) begin
            d_cnt--;
            if (d_cnt == 0) auto_dd = 1'b1;
        end
        if (i_cnt > 0) begin
            i_cnt--;
            if (i_cnt == 0) auto_di = 1'b1;
        end
        if (dflush_req) begin
            d_cyc = cyc;
            if (auto_d_en) d_cnt = 3;
        end
        if (iflush_req) begin
            i_cyc = cyc;
            if (auto_i_en) i_cnt = 2;
        end
    endtask

    task automatic wait_flush(input bit is_i, input string tag, output int c);
        int n;
        n = 0;
        while (!(is_i ? iflush_req : dflush_req) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check(tag, 0, 1);
        c = cyc;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) check(tag, int'(busy), 0);
    endtask

    task automatic send(input logic [3:0] r, input logic [7:0] t, input bit expect_ack);
        tick();
        req     = r;
        req_tgt = t;
        if (expect_ack) exp_q.push_back(r);
        $display("cycle %0d req=%b tgt=%b", cyc, r, t);
        tick();
        req     = '0;
        req_tgt = '0;
    endtask

    initial begin
        int t0;
        repeat (3) tick();
        check("rst_ack", int'(ack), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_stall", int'(pipe_stall), 0);
        check("rst_dreq", int'(dflush_req), 0);
        check("rst_ireq", int'(iflush_req), 0);
        check("rst_err", int'(timeout_err), 0);
        rst = 1'b0;
        repeat (2) tick();

        // Cycle-exact single request with manually timed completions
        for (int c = 0; c <= 10; c++) begin
            tick();
            req     = (c == 0) ? 4'b0001 : 4'b0000;
            req_tgt = (c == 0) ? 8'b0000_0011 : 8'b0;
            if (c == 0) exp_q.push_back(4'b0001);
            man_dd  = (c == 5);
            man_di  = (c == 8);
            check("t1_stall", int'(pipe_stall), (c >= 2 && c <= 8) ? 1 : 0);
            check("t1_dreq", int'(dflush_req), (c == 3) ? 1 : 0);
            check("t1_ireq", int'(iflush_req), (c == 6) ? 1 : 0);
            check("t1_ack", int'(ack), (c == 9) ? 1 : 0);
            check("t1_busy", int'(busy), (c >= 1 && c <= 9) ? 1 : 0);
        end
        man_dd = 1'b0;
        man_di = 1'b0;

        // Two requesters in one cycle: merged targets, single combined ack
        auto_d_en = 1'b1;
        auto_i_en = 1'b1;
        d_cyc = -1;
        i_cyc = -1;
        send(4'b1010, 8'b10_00_01_00, 1'b1);
        wait_idle("t2_idle_timeout");
        check("t2_d_before_i", (d_cyc >= 0 && i_cyc > d_cyc) ? 1 : 0, 1);

        // Request arriving mid-flush waits for the next batch
        send(4'b0001, 8'b0000_0011, 1'b1);
        wait_flush(1'b0, "t3_dreq_timeout", t0);
        req     = 4'b0100;
        req_tgt = 8'b0011_0000;
        exp_q.push_back(4'b0100);
        tick();
        req     = '0;
        req_tgt = '0;
        wait_idle("t3_idle_timeout");

        // D-cache never completes: timeout decision when the timer reaches 64
        auto_d_en = 1'b0;
        send(4'b0001, 8'b0000_0001, 1'b1);
        wait_flush(1'b0, "t4_dreq_timeout", t0);
        while (cyc < t0 + 64) tick();
        check("t4_err_before", int'(timeout_err), 0);
        check("t4_stall_hold", int'(pipe_stall), 1);
        tick();
        check("t4_err_set", int'(timeout_err), 1);
        check("t4_release_ack", int'(ack), 1);
        check("t4_release_stall", int'(pipe_stall), 0);
        repeat (3) tick();
        check("t4_err_sticky", int'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr", int'(timeout_err), 0);
        send(4'b0001, 8'b0000_0001, 1'b1);
        wait_flush(1'b0, "t4b_dreq_timeout", t0);
        while (cyc < t0 + 64) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_set_beats_clr", int'(timeout_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr2", int'(timeout_err), 0);
        wait_idle("t4_idle_timeout");

        // Pipeline not drained: no flush request, stray completions ignored
        auto_d_en = 1'b1;
        pipe_idle = 1'b0;
        send(4'b0001, 8'b0000_0011, 1'b1);
        for (int k = 0; k < 20; k++) begin
            tick();
            man_di = (k == 5);
            man_dd = (k == 8);
            check("t5_no_dreq", int'(dflush_req | iflush_req), 0);
        end
        man_di = 1'b0;
        man_dd = 1'b0;
        check("t5_stall", int'(pipe_stall), 1);
        pipe_idle = 1'b1;
        wait_flush(1'b0, "t5_dreq_timeout", t0);
        wait_idle("t5_idle_timeout");

        // Reset during the I-cache flush drops the batch without an ack
        auto_i_en = 1'b0;
        send(4'b0001, 8'b0000_0011, 1'b0);
        wait_flush(1'b1, "t6_ireq_timeout", t0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_ack", int'(ack), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_stall", int'(pipe_stall), 0);
        check("t6_dreq", int'(dflush_req), 0);
        check("t6_ireq", int'(iflush_req), 0);
        tick();
        man_di = 1'b1;
        tick();
        man_di = 1'b0;
        repeat (8) tick();
        check("t6_still_idle", int'(busy | pipe_stall), 0);

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
